if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Parametrised fetch-to-decode buffer; successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH {instruction, PC} entries between Fetcher and Decoder.
- Uses valid/ready handshakes on both sides, so fetch can run ahead while decode stalls.
- A flush input discards all buffered entries on a branch redirect.

Parameters:
- INST_WIDTH, `instWidth (32): instruction word width.
- ADDR_WIDTH, `addrWidth (32): PC width.
- DEPTH, 2: number of entries. Legal range 2..16; any integer, not restricted to powers of two.
- CNT_WIDTH, $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: discard all entries (branch/jump redirect).
- in_valid, input, 1: Fetcher presents an entry.
- in_ready, output, 1: queue can accept an entry.
- in_inst, input, INST_WIDTH: fetched instruction.
- in_pc, input, ADDR_WIDTH: PC of the fetched instruction.
- out_valid, output, 1: head entry is valid for the Decoder.
- out_ready, input, 1: Decoder consumes the head entry (deasserted on decode stall).
- out_inst, output, INST_WIDTH: head instruction.
- out_pc, output, ADDR_WIDTH: head PC.
- count, output, CNT_WIDTH: current occupancy.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - Outputs: out_valid = 0, out_inst = 0, out_pc = 0, in_ready = 1.
  - Storage contents are don't-care.
  - Reset asserted mid-operation drops all entries immediately; no partial state survives.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready = (count != DEPTH).
  - Registered-state function only; no combinational path from out_ready.
  - When full, a push in the same cycle as a pop is refused.
- out_valid = (count != 0).
- out_inst/out_pc:
  - Driven from the entry at rd_ptr when out_valid = 1.
  - Forced to 0 when out_valid = 0, keeping the decoder's zero-bubble convention.
- Pointer update:
  - push writes entry[wr_ptr] and advances wr_ptr.
  - pop advances rd_ptr.
  - Each pointer wraps from DEPTH-1 to 0 by explicit compare, not by bit overflow.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed in cycle N is visible on out_valid/out_inst in cycle N+1 (registered storage).
- Order: strict FIFO.
- Flush:
  - Highest priority.
  - In a cycle with flush = 1, push and pop are suppressed.
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0, out_valid = 0.
  - in_ready stays as computed from the pre-flush count during the flush cycle. Fetcher must treat that cycle's entry as dropped regardless of in_ready.
- Boundaries:
  - Empty with pop requested: no-op (out_valid = 0, so pop cannot occur).
  - Full with push attempted: refused, in_ready = 0.
  - Full with pop: in_ready rises the following cycle.
  - Count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: IF_ID_QUEUE_BYPASS_EN.
- Defined:
  - When count = 0 and in_valid = 1 and flush = 0, out_valid = 1 combinationally.
  - out_inst/out_pc equal in_inst/in_pc in the same cycle.
  - If out_ready = 1 the entry passes through and is not written; count stays 0.
  - If out_ready = 0 it is written normally.
  - Zero-cycle latency when empty.
- Not defined: behaviour exactly as above, with one-cycle latency in all cases.

Decomposition:
- Shared defines header provides `instWidth and `addrWidth, used as parameter defaults.
- No new package types are required.
- Optional sub-module if_id_queue_ptr: wrapping pointer counter with inc and clear inputs, instantiated twice (wr/rd).
- Storage stays inline.

Test Plan:
- Reset: rst_n low mid-traffic with count = 2 -> immediately out_valid = 0, out_inst = 0, out_pc = 0, count = 0, in_ready = 1.
- Fill, DEPTH = 2, out_ready = 0: push 0x00000013 @PC 0x0, then 0x00100093 @PC 0x4 -> count = 2, in_ready = 0. A third push of 0x00200113 is refused. out_inst = 0x00000013, out_pc = 0x0.
- Drain order: from full, out_ready = 1 for 2 cycles -> outputs 0x00000013/0x0 then 0x00100093/0x4, then out_valid = 0 and out_inst = 0.
- Simultaneous push+pop: at count = 1, push 0xDEADBEEF @PC 0x8 with out_ready = 1 for 4 cycles -> count stays 1; pointers wrap past DEPTH-1 with no lost or duplicated entries.
- Flush: count = 2, flush = 1 together with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0; neither the flushed entries nor the input entry ever appear.
- Bypass (macro defined): empty queue, in_valid = 1, in_inst = 0xCAFEF00D, out_ready = 1 -> same-cycle out_valid = 1, out_inst = 0xCAFEF00D, count stays 0. Without the macro: out_valid rises next cycle and count = 1.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// ============================================================================
// Module      : if_id_queue_pkg
// Description : Shared constants and helpers for the fetch-to-decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_id_queue_pkg;

    localparam int unsigned DEFAULT_DEPTH = 2;

    // Pointer width for a DEPTH-entry ring; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_id_queue_ptr.sv
// ============================================================================
// Module      : if_id_queue_ptr
// Description : Ring pointer wrapping from DEPTH-1 to 0, with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_queue_ptr
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int PTR_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clear,
    output logic [PTR_WIDTH-1:0] ptr
);

    // Explicit compare keeps non-power-of-two depths wrapping correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_id_queue.sv
// ============================================================================
// Module      : if_id_queue
// Description : DEPTH-entry {instruction, PC} FIFO between Fetcher and Decoder.
//               Optional macro IF_ID_QUEUE_BYPASS_EN adds empty-queue bypass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef instWidth
`define instWidth 32
`endif
`ifndef addrWidth
`define addrWidth 32
`endif

module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int INST_WIDTH = `instWidth,
    parameter int ADDR_WIDTH = `addrWidth,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int PTR_WIDTH = ptr_width(DEPTH);

    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  stored;
    logic                  pass_through;
    logic                  push;
    logic                  pop;

    assign stored   = (count != '0);
    assign in_ready = (count != CNT_WIDTH'(DEPTH));

`ifdef IF_ID_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = !stored && in_valid && !flush;
    assign pass_through = bypass && out_ready;
    assign out_valid    = stored || bypass;
    assign out_inst     = stored ? inst_mem[rd_ptr] : (bypass ? in_inst : '0);
    assign out_pc       = stored ? pc_mem[rd_ptr]   : (bypass ? in_pc   : '0);
`else
    assign pass_through = 1'b0;
    assign out_valid    = stored;
    assign out_inst     = stored ? inst_mem[rd_ptr] : '0;
    assign out_pc       = stored ? pc_mem[rd_ptr]   : '0;
`endif

    // Flush suppresses both handshakes; a bypassed entry never touches storage.
    assign push = in_valid && in_ready && !flush && !pass_through;
    assign pop  = stored && out_ready && !flush;

    if_id_queue_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clear (flush),
        .ptr   (wr_ptr)
    );

    if_id_queue_ptr #(.DEPTH(DEPTH), .PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clear (flush),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_WIDTH'(1);
        end else if (pop && !push) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
// Module      : tb_if_id_queue
// Description : Self-checking bench for if_id_queue against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int IW    = 32;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [IW-1:0] in_inst   = '0;
    logic [AW-1:0] in_pc     = '0;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_inst;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [IW-1:0] inst;
        logic [AW-1:0] pc;
    } ent_t;

    ent_t q[$];

    logic          e_valid;
    logic          e_ready;
    logic [IW-1:0] e_inst;
    logic [AW-1:0] e_pc;
    logic [CW-1:0] e_count;

    if_id_queue #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current inputs, from the model queue.
    task automatic expect_now();
        e_count = CW'(q.size());
        e_ready = (q.size() < DEPTH);
        if (q.size() > 0) begin
            e_valid = 1'b1;
            e_inst  = q[0].inst;
            e_pc    = q[0].pc;
        end
`ifdef IF_ID_QUEUE_BYPASS_EN
        else if (in_valid && !flush) begin
            e_valid = 1'b1;
            e_inst  = in_inst;
            e_pc    = in_pc;
        end
`endif
        else begin
            e_valid = 1'b0;
            e_inst  = '0;
            e_pc    = '0;
        end
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] i, input logic [AW-1:0] p,
                         input logic r, input logic f);
        in_valid  = v;
        in_inst   = i;
        in_pc     = p;
        out_ready = r;
        flush     = f;
        #1;
        expect_now();
    endtask

    // Clock edge: apply the queue rules to the model, return at the next negedge.
    task automatic advance();
        ent_t e;
        bit   was_empty;
        bit   do_pop;
        bit   do_push;
        was_empty = (q.size() == 0);
        do_pop    = !was_empty && out_ready;
        do_push   = in_valid && e_ready && !(was_empty && e_valid && out_ready);
        e.inst    = in_inst;
        e.pc      = in_pc;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || out_inst !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b ready=%b count=%0d inst=%h pc=%h, expected 0 1 0 0 0",
                     out_valid, in_ready, count, out_inst, out_pc);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h1111_0001, 32'h100, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h1111_0002, 32'h104, 1'b0, 1'b0); advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL reset_precount: got %0d, expected 2", count);
        end
        rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || out_inst !== '0 || out_pc !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b ready=%b count=%0d inst=%h pc=%h, expected 0 1 0 0 0",
                     out_valid, in_ready, count, out_inst, out_pc);
        end
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        drive(1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h0010_0093, 32'h4, 1'b0, 1'b0); advance();
        drive(1'b1, 32'h0020_0113, 32'h8, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(2) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: count=%0d ready=%b, expected 2 0", count, in_ready);
        end
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(2) || out_inst !== 32'h0000_0013 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL fill_refused: count=%0d inst=%h pc=%h, expected 2 00000013 0", count, out_inst, out_pc);
        end
    endtask

    task automatic test_drain();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0000_0013 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL drain_first: valid=%b inst=%h pc=%h, expected 1 00000013 0", out_valid, out_inst, out_pc);
        end
        advance();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_inst !== 32'h0010_0093 || out_pc !== 32'h4 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_second: inst=%h pc=%h ready=%b, expected 00100093 4 1", out_inst, out_pc, in_ready);
        end
        advance();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || out_inst !== '0 || count !== '0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b inst=%h count=%0d, expected 0 0 0", out_valid, out_inst, count);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h0BAD_0000, 32'h4, 1'b0, 1'b0); advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'hDEAD_BEEF + IW'(i), 32'h8 + AW'(4 * i), 1'b1, 1'b0);
            checks++;
            if (count !== CW'(1) || out_inst !== ((i == 0) ? 32'h0BAD_0000 : 32'hDEAD_BEEF + IW'(i - 1))) begin
                errors++;
                $display("FAIL b2b_%0d: count=%0d inst=%h, expected 1 and model head %h", i, count, out_inst, e_inst);
            end
            advance();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_inst !== 32'hDEAD_BEF2 || out_pc !== 32'h14) begin
            errors++;
            $display("FAIL b2b_last: inst=%h pc=%h, expected deadbef2 14", out_inst, out_pc);
        end
        advance();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hF100_0001, 32'h20, 1'b0, 1'b0); advance();
        drive(1'b1, 32'hF100_0002, 32'h24, 1'b0, 1'b0); advance();
        drive(1'b1, 32'hF100_0003, 32'h28, 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got %b, expected 0", in_ready);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, '0, 1'b1, 1'b0);
            checks++;
            if (count !== '0 || out_valid !== 1'b0 || out_inst !== '0) begin
                errors++;
                $display("FAIL flush_after_%0d: count=%0d valid=%b inst=%h, expected 0 0 0", i, count, out_valid, out_inst);
            end
            advance();
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'hCAFE_F00D, 32'h40, 1'b1, 1'b0);
`ifdef IF_ID_QUEUE_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'hCAFE_F00D || out_pc !== 32'h40) begin
            errors++;
            $display("FAIL bypass_same: valid=%b inst=%h pc=%h, expected 1 cafef00d 40", out_valid, out_inst, out_pc);
        end
        advance();
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_after: count=%0d valid=%b, expected 0 0", count, out_valid);
        end
`else
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bypass_same: valid=%b, expected 0", out_valid);
        end
        advance();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (count !== CW'(1) || out_valid !== 1'b1 || out_inst !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL bypass_after: count=%0d valid=%b inst=%h, expected 1 1 cafef00d", count, out_valid, out_inst);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
`endif
        advance();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 2) != 0), IW'($urandom), AW'($urandom & 32'hFFFC),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 24) == 0));
            checks++;
            if ({out_valid, in_ready, count} !== {e_valid, e_ready, e_count} ||
                out_inst !== e_inst || out_pc !== e_pc) begin
                errors++;
                $display("FAIL random_%0d: v/r/c=%b/%b/%0d inst=%h pc=%h, expected %b/%b/%0d %h %h",
                         n, out_valid, in_ready, count, out_inst, out_pc,
                         e_valid, e_ready, e_count, e_inst, e_pc);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
